fxp_product_normalize: RTL and testbench

- Downstream stage of fixed_multiply. Consumes its full-width signed product, which carries 2*fractional_size fractional bits.
- Rounds and rescales the product back to operand_size bits with fractional_size fractional bits, and saturates on overflow.
- Two-stage pipeline with valid/ready handshakes on both sides. Provides a per-sample saturation flag and a saturation event counter for DSP chain monitoring.

---
 rtl/fxp_product_normalize.sv | 96 +++++++++
 tb/tb_fxp_product_normalize.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fxp_product_normalize.sv
// Rounds a 2*operand_size fixed-point product back to operand_size bits, saturating on overflow.
// Latency: 2 cycles, 1 sample/cycle. Backpressure: i_ready stalls both stages, o_ready is combinational.
// Saturated transfers are counted in a sticky, clearable event counter.
module fxp_product_normalize #(
  parameter int fractional_size = 12,
  parameter int operand_size    = 32,
  parameter int count_size      = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [2*operand_size-1:0] i_product,
  input  logic                      i_valid,
  output logic                      o_ready,
  output logic [operand_size-1:0]   o_res,
  output logic                      o_sat,
  output logic                      o_valid,
  input  logic                      i_ready,
  input  logic                      i_clr_count,
  output logic [count_size-1:0]     o_sat_count
);

  localparam int PW = 2 * operand_size;
  localparam int SW = PW + 1;

  localparam logic signed [SW-1:0] RND  =
    {{(SW-fractional_size){1'b0}}, 1'b1, {(fractional_size-1){1'b0}}};
  localparam logic signed [SW-1:0] MAXV =
    {{(SW-operand_size+1){1'b0}}, {(operand_size-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV =
    {{(SW-operand_size+1){1'b1}}, {(operand_size-1){1'b0}}};
  localparam logic [count_size-1:0] CNT_ONE = {{(count_size-1){1'b0}}, 1'b1};

  logic                     s1_valid_q;
  logic signed [SW-1:0]     s1_val_q, s1_val_d, sum;
  logic                     s2_valid_q;
  logic [operand_size-1:0]  res_q, res_d;
  logic                     sat_q, sat_d;
  logic [count_size-1:0]    sat_cnt_q, sat_cnt_d;
  logic                     en1, en2;

  assign en2     = i_ready || !s2_valid_q;
  assign en1     = en2 || !s1_valid_q;
  assign o_ready = en1;

  always_comb begin
    // One extra bit of headroom makes the rounding add overflow-free.
    sum      = $signed({i_product[PW-1], i_product}) + RND;
    s1_val_d = sum >>> fractional_size;
    res_d    = s1_val_q[operand_size-1:0];
    sat_d    = 1'b0;
    if (s1_val_q > MAXV) begin
      res_d = {1'b0, {(operand_size-1){1'b1}}};
      sat_d = 1'b1;
    end else if (s1_val_q < MINV) begin
      res_d = {1'b1, {(operand_size-1){1'b0}}};
      sat_d = 1'b1;
    end
  end

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (i_clr_count) begin
      sat_cnt_d = '0;
    end else if (s2_valid_q && i_ready && sat_q && (sat_cnt_q != '1)) begin
      sat_cnt_d = sat_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_val_q   <= '0;
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      sat_q      <= 1'b0;
      sat_cnt_q  <= '0;
    end else begin
      if (en1) begin
        s1_valid_q <= i_valid;
        s1_val_q   <= s1_val_d;
      end
      if (en2) begin
        s2_valid_q <= s1_valid_q;
        res_q      <= res_d;
        sat_q      <= sat_d;
      end
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign o_valid     = s2_valid_q;
  assign o_res       = res_q;
  assign o_sat       = sat_q;
  assign o_sat_count = sat_cnt_q;

endmodule

// File: tb/tb_fxp_product_normalize.sv
// Self-checking bench for fxp_product_normalize: vector table, scoreboard queue and
// hand-written sequences for latency, back-pressure, counter saturation/clear and reset.
module tb_fxp_product_normalize;

  typedef struct {
    logic [63:0] prod;
    logic [31:0] res;
    logic        sat;
  } vec_t;

  localparam longint MAXL = 64'sd2147483647;
  localparam longint MINL = -64'sd2147483648;

  logic        clk;
  logic        rst_n;
  logic [63:0] i_product;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] o_res;
  logic        o_sat;
  logic        o_valid;
  logic        i_ready;
  logic        i_clr_count;
  logic [15:0] o_sat_count;

  int errors = 0;
  int checks = 0;
  logic [32:0] exp_q[$];
  logic        stall_prev = 1'b0;
  logic [31:0] held_res;
  logic        held_sat;
  logic        saw_full = 1'b0;

  fxp_product_normalize #(
    .fractional_size(12),
    .operand_size(32),
    .count_size(16)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_product(i_product),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_res(o_res),
    .o_sat(o_sat),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .i_clr_count(i_clr_count),
    .o_sat_count(o_sat_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: floor division by 4096, plus one when the dropped fraction is >= one half.
  function automatic void model(input logic [63:0] p, output logic [31:0] r, output logic s);
    longint q;
    q = $signed(p);
    q = q >>> 12;
    if (p[11]) q = q + 1;
    if (q > MAXL) begin
      r = 32'h7FFFFFFF; s = 1'b1;
    end else if (q < MINL) begin
      r = 32'h80000000; s = 1'b1;
    end else begin
      r = q[31:0]; s = 1'b0;
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        chk("stall_hold_valid", {63'd0, o_valid}, 64'd1);
        chk("stall_hold_res", {32'd0, o_res}, {32'd0, held_res});
        chk("stall_hold_sat", {63'd0, o_sat}, {63'd0, held_sat});
      end
      if (o_valid && !i_ready && !o_ready) saw_full = 1'b1;
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got res=%0h with empty scoreboard", o_res);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          chk("out_res", {32'd0, o_res}, {32'd0, e[31:0]});
          chk("out_sat", {63'd0, o_sat}, {63'd0, e[32]});
        end
      end
      stall_prev = o_valid && !i_ready;
      held_res   = o_res;
      held_sat   = o_sat;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Presents one sample from posedge+1 until accepted; returns at posedge+1 after the transfer.
  task automatic push(input logic [63:0] p, input logic [31:0] r, input logic s);
    bit ok;
    ok = 1'b0;
    i_product = p;
    i_valid   = 1'b1;
    for (int n = 0; n < 500 && !ok; n++) begin
      @(negedge clk);
      ok = o_ready;
      @(posedge clk);
      if (ok) exp_q.push_back({s, r});
      #1;
    end
    i_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: o_ready stuck low, required 1");
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      done = (exp_q.size() == 0);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d outputs missing, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Called right after push() returned for a sample entering an empty pipe.
  task automatic latency_check(input string name);
    @(negedge clk);
    chk({name, "_lat1"}, {63'd0, o_valid}, 64'd0);
    @(negedge clk);
    chk({name, "_lat2"}, {63'd0, o_valid}, 64'd1);
  endtask

  // Asserts i_clr_count in the cycle the next output transfers.
  task automatic sat_with_clear(input bit clr, input logic [15:0] exp_cnt, input string name);
    bit seen;
    seen = 1'b0;
    push(64'h0000_0800_0000_0000, 32'h7FFFFFFF, 1'b1);
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      seen = o_valid;
    end
    i_clr_count = clr;
    @(posedge clk);
    #1;
    i_clr_count = 1'b0;
    chk({name, "_seen"}, {63'd0, seen}, 64'd1);
    chk(name, {48'd0, o_sat_count}, {48'd0, exp_cnt});
  endtask

  initial begin
    vec_t vecs[10];
    int   exp_cnt;
    logic [31:0] r;
    logic        s;
    logic signed [63:0] ps;

    vecs[0] = '{64'd2047, 32'd0, 1'b0};
    vecs[1] = '{64'd2048, 32'd1, 1'b0};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_F800, 32'd0, 1'b0};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_F7FF, 32'hFFFFFFFF, 1'b0};
    vecs[4] = '{64'h0000_0800_0000_0000, 32'h7FFFFFFF, 1'b1};
    vecs[5] = '{64'hFFFF_F800_0000_0000, 32'h80000000, 1'b0};
    vecs[6] = '{64'hFFFF_F7FF_FFFF_F000, 32'h80000000, 1'b1};
    vecs[7] = '{64'h0000_07FF_FFFF_F000, 32'h7FFFFFFF, 1'b0};
    vecs[8] = '{64'h0000_07FF_FFFF_F7FF, 32'h7FFFFFFF, 1'b0};
    vecs[9] = '{64'h0000_07FF_FFFF_F800, 32'h7FFFFFFF, 1'b1};

    rst_n       = 1'b0;
    i_product   = '0;
    i_valid     = 1'b0;
    i_ready     = 1'b1;
    i_clr_count = 1'b0;

    #1;
    chk("rst_valid", {63'd0, o_valid}, 64'd0);
    chk("rst_res", {32'd0, o_res}, 64'd0);
    chk("rst_sat", {63'd0, o_sat}, 64'd0);
    chk("rst_count", {48'd0, o_sat_count}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_ready", {63'd0, o_ready}, 64'd1);

    // Basic scaling with latency.
    @(posedge clk);
    #1;
    push(64'd100663296, 32'd24576, 1'b0);
    latency_check("basic");
    drain();

    // Rounding and saturation vectors back to back.
    exp_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      push(vecs[i].prod, vecs[i].res, vecs[i].sat);
      if (vecs[i].sat) exp_cnt++;
    end
    drain();
    chk("table_sat_count", {48'd0, o_sat_count}, 64'(exp_cnt));

    // Back-pressure: i_ready low for five cycles in the middle of a stream.
    saw_full = 1'b0;
    fork
      begin
        for (int k = 0; k < 10; k++) push(64'(k) * 64'd4096, 32'(k), 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 i_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 i_ready = 1'b1;
      end
    join
    drain();
    chk("bp_ready_dropped", {63'd0, saw_full}, 64'd1);

    // Random products with random back-pressure.
    fork
      begin
        for (int k = 0; k < 60; k++) begin
          ps = {$urandom, $urandom};
          ps = ps >>> $urandom_range(0, 40);
          model(ps, r, s);
          push(ps, r, s);
        end
      end
      begin
        repeat (150) begin
          @(posedge clk);
          #1 i_ready = 1'($urandom_range(0, 1));
        end
        i_ready = 1'b1;
      end
    join
    i_ready = 1'b1;
    drain();

    // Counter sticks at all-ones.
    for (int k = 0; k < 70000; k++) push(64'h0000_0800_0000_0000, 32'h7FFFFFFF, 1'b1);
    drain();
    chk("count_sticky", {48'd0, o_sat_count}, 64'd65535);
    sat_with_clear(1'b1, 16'd0, "clr_at_max");
    drain();
    sat_with_clear(1'b1, 16'd0, "clr_vs_inc");
    drain();
    sat_with_clear(1'b0, 16'd1, "inc_after_clr");
    drain();

    // Asynchronous reset with both stages full.
    i_ready = 1'b0;
    push(64'd4096, 32'd1, 1'b0);
    push(64'd8192, 32'd2, 1'b0);
    chk("pre_rst_valid", {63'd0, o_valid}, 64'd1);
    chk("pre_rst_ready", {63'd0, o_ready}, 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {63'd0, o_valid}, 64'd0);
    chk("mid_rst_count", {48'd0, o_sat_count}, 64'd0);
    chk("mid_rst_res", {32'd0, o_res}, 64'd0);
    exp_q.delete();
    i_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {63'd0, o_ready}, 64'd1);
    @(posedge clk);
    #1;
    push(64'd12288, 32'd3, 1'b0);
    latency_check("post_rst");
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
